// File: rtl/mem_stage.sv
// mem_stage: memory pipeline stage with valid/ready handoff, load/store lane steering and branch resolve
//
// Ports:
//   i_clk, i_rst            clock, asynchronous active-high reset
//   i_valid / o_ready       EX result handshake; transfer when both are 1
//   i_ALUResult..i_rd       EX result, store data and control
//   o_mem_*, i_mem_*        single-outstanding memory request, held until i_mem_ack
//   o_valid..o_misaligned   writeback outputs, o_valid pulses one cycle per op
//
// Build option: MEM_MISALIGN_TRAP_EN enables misalignment trapping on LH/LHU/SH
// and LW/SW; without it o_misaligned stays 0 and accesses are aligned down.
module mem_stage (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic [31:0] i_ALUResult,
    input  logic [31:0] i_PCBranch,
    input  logic        i_zero,
    input  logic        i_negative,
    input  logic [31:0] i_register2,
    input  logic        i_MemRead,
    input  logic        i_MemWrite,
    input  logic        i_Branch,
    input  logic        i_RegWrite,
    input  logic        i_MemToReg,
    input  logic [2:0]  i_funct3,
    input  logic [4:0]  i_rd,
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    output logic [3:0]  o_mem_be,
    input  logic        i_mem_ack,
    input  logic [31:0] i_mem_rdata,
    output logic        o_valid,
    output logic [31:0] o_result,
    output logic [4:0]  o_rd,
    output logic        o_RegWrite,
    output logic        o_PCSrc,
    output logic [31:0] o_PCBranch,
    output logic        o_misaligned
);
    typedef enum logic {IDLE, ACCESS} state_t;
    state_t      state_q, state_d;
    logic        mem_req_q, mem_req_d, mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
    logic [3:0]  mem_be_q, mem_be_d;
    logic        valid_q, valid_d, regwrite_q, regwrite_d, pcsrc_q, pcsrc_d;
    logic        misaligned_q, misaligned_d;
    logic [31:0] result_q, result_d, pcbranch_q, pcbranch_d;
    logic [4:0]  rd_q, rd_d;
    // Pending copies of the op held while the memory access is outstanding,
    // so the visible writeback outputs keep their previous values meanwhile.
    logic [2:0]  f3_p_q, f3_p_d;
    logic [1:0]  lo_p_q, lo_p_d;
    logic        ld_p_q, ld_p_d, rw_p_q, rw_p_d, br_p_q, br_p_d;
    logic [31:0] alu_p_q, alu_p_d, pcb_p_q, pcb_p_d;
    logic [4:0]  rd_p_q, rd_p_d;
    logic        xfer, mem_op, cond, mis;
    logic [1:0]  a;
    logic [3:0]  be_w;
    logic [31:0] wdata_w, ld_w;
    logic [7:0]  byte_w;
    logic [15:0] half_w;

    assign o_ready      = (state_q == IDLE);
    assign xfer         = i_valid && o_ready;
    assign mem_op       = i_MemRead || i_MemWrite;
    assign a            = i_ALUResult[1:0];
    assign cond         = (i_funct3 == 3'b000) ? i_zero :
                          (i_funct3 == 3'b001) ? !i_zero :
                          (i_funct3 == 3'b100) ? i_negative :
                          (i_funct3 == 3'b101) ? !i_negative : 1'b0;
    // Half accesses use the lane picked by addr[1]; this matches the shifted
    // enable for aligned halves and gives the aligned-down lane otherwise.
    assign be_w         = (i_funct3[1:0] == 2'b00) ? (4'b0001 << a) :
                          (i_funct3[1:0] == 2'b01) ? (a[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    assign wdata_w      = (i_funct3[1:0] == 2'b00) ? {4{i_register2[7:0]}} :
                          (i_funct3[1:0] == 2'b01) ? {2{i_register2[15:0]}} : i_register2;
    assign byte_w       = (lo_p_q == 2'd0) ? i_mem_rdata[7:0]   :
                          (lo_p_q == 2'd1) ? i_mem_rdata[15:8]  :
                          (lo_p_q == 2'd2) ? i_mem_rdata[23:16] : i_mem_rdata[31:24];
    assign half_w       = lo_p_q[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];
    assign ld_w         = (f3_p_q == 3'b000) ? {{24{byte_w[7]}}, byte_w} :
                          (f3_p_q == 3'b001) ? {{16{half_w[15]}}, half_w} :
                          (f3_p_q == 3'b100) ? {24'b0, byte_w} :
                          (f3_p_q == 3'b101) ? {16'b0, half_w} : i_mem_rdata;
`ifdef MEM_MISALIGN_TRAP_EN
    assign mis          = mem_op && (((i_funct3[1:0] == 2'b01) && a[0]) ||
                                     ((i_funct3[1:0] == 2'b10) && (a != 2'b00)));
`else
    assign mis          = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_be_d     = mem_be_q;
        valid_d      = 1'b0;
        regwrite_d   = 1'b0;
        pcsrc_d      = 1'b0;
        misaligned_d = 1'b0;
        result_d     = result_q;
        rd_d         = rd_q;
        pcbranch_d   = pcbranch_q;
        f3_p_d       = f3_p_q;
        lo_p_d       = lo_p_q;
        ld_p_d       = ld_p_q;
        rw_p_d       = rw_p_q;
        br_p_d       = br_p_q;
        alu_p_d      = alu_p_q;
        pcb_p_d      = pcb_p_q;
        rd_p_d       = rd_p_q;
        if (xfer && (!mem_op || mis)) begin
            valid_d      = 1'b1;
            result_d     = i_ALUResult;
            rd_d         = i_rd;
            regwrite_d   = i_RegWrite && !mis;
            pcsrc_d      = i_Branch && cond;
            pcbranch_d   = i_PCBranch;
            misaligned_d = mis;
        end else if (xfer) begin
            state_d     = ACCESS;
            mem_req_d   = 1'b1;
            mem_we_d    = i_MemWrite;
            mem_addr_d  = {i_ALUResult[31:2], 2'b00};
            mem_wdata_d = wdata_w;
            mem_be_d    = be_w;
            f3_p_d      = i_funct3;
            lo_p_d      = a;
            // Both MemRead and MemWrite set is a store: no load data, no register write.
            ld_p_d      = i_MemRead && !i_MemWrite && i_MemToReg;
            rw_p_d      = i_RegWrite && !i_MemWrite;
            br_p_d      = i_Branch && cond;
            alu_p_d     = i_ALUResult;
            pcb_p_d     = i_PCBranch;
            rd_p_d      = i_rd;
        end else if (state_q == ACCESS && i_mem_ack) begin
            state_d    = IDLE;
            mem_req_d  = 1'b0;
            mem_we_d   = 1'b0;
            valid_d    = 1'b1;
            result_d   = ld_p_q ? ld_w : alu_p_q;
            rd_d       = rd_p_q;
            regwrite_d = rw_p_q;
            pcsrc_d    = br_p_q;
            pcbranch_d = pcb_p_q;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q      <= IDLE;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_be_q     <= '0;
            valid_q      <= 1'b0;
            regwrite_q   <= 1'b0;
            pcsrc_q      <= 1'b0;
            misaligned_q <= 1'b0;
            result_q     <= '0;
            rd_q         <= '0;
            pcbranch_q   <= '0;
            f3_p_q       <= '0;
            lo_p_q       <= '0;
            ld_p_q       <= 1'b0;
            rw_p_q       <= 1'b0;
            br_p_q       <= 1'b0;
            alu_p_q      <= '0;
            pcb_p_q      <= '0;
            rd_p_q       <= '0;
        end else begin
            state_q      <= state_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_be_q     <= mem_be_d;
            valid_q      <= valid_d;
            regwrite_q   <= regwrite_d;
            pcsrc_q      <= pcsrc_d;
            misaligned_q <= misaligned_d;
            result_q     <= result_d;
            rd_q         <= rd_d;
            pcbranch_q   <= pcbranch_d;
            f3_p_q       <= f3_p_d;
            lo_p_q       <= lo_p_d;
            ld_p_q       <= ld_p_d;
            rw_p_q       <= rw_p_d;
            br_p_q       <= br_p_d;
            alu_p_q      <= alu_p_d;
            pcb_p_q      <= pcb_p_d;
            rd_p_q       <= rd_p_d;
        end
    end

    assign o_mem_req    = mem_req_q;
    assign o_mem_we     = mem_we_q;
    assign o_mem_addr   = mem_addr_q;
    assign o_mem_wdata  = mem_wdata_q;
    assign o_mem_be     = mem_be_q;
    assign o_valid      = valid_q;
    assign o_result     = result_q;
    assign o_rd         = rd_q;
    assign o_RegWrite   = regwrite_q;
    assign o_PCSrc      = pcsrc_q;
    assign o_PCBranch   = pcbranch_q;
    assign o_misaligned = misaligned_q;
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: randomized and directed checks of mem_stage against a behavioural model
module tb_mem_stage;
    logic        i_clk = 0, i_rst = 1, i_valid = 0, o_ready;
    logic [31:0] i_ALUResult = 0, i_PCBranch = 0, i_register2 = 0;
    logic        i_zero = 0, i_negative = 0, i_MemRead = 0, i_MemWrite = 0;
    logic        i_Branch = 0, i_RegWrite = 0, i_MemToReg = 0;
    logic [2:0]  i_funct3 = 0;
    logic [4:0]  i_rd = 0;
    logic        o_mem_req, o_mem_we, i_mem_ack = 0;
    logic [31:0] o_mem_addr, o_mem_wdata, i_mem_rdata = 0;
    logic [3:0]  o_mem_be;
    logic        o_valid, o_RegWrite, o_PCSrc, o_misaligned;
    logic [31:0] o_result, o_PCBranch;
    logic [4:0]  o_rd;
    int          checks = 0, errors = 0;
    logic [31:0] last_result = 0;

    mem_stage dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_ALUResult(i_ALUResult), .i_PCBranch(i_PCBranch), .i_zero(i_zero),
        .i_negative(i_negative), .i_register2(i_register2), .i_MemRead(i_MemRead),
        .i_MemWrite(i_MemWrite), .i_Branch(i_Branch), .i_RegWrite(i_RegWrite),
        .i_MemToReg(i_MemToReg), .i_funct3(i_funct3), .i_rd(i_rd),
        .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
        .o_mem_wdata(o_mem_wdata), .o_mem_be(o_mem_be), .i_mem_ack(i_mem_ack),
        .i_mem_rdata(i_mem_rdata), .o_valid(o_valid), .o_result(o_result), .o_rd(o_rd),
        .o_RegWrite(o_RegWrite), .o_PCSrc(o_PCSrc), .o_PCBranch(o_PCBranch),
        .o_misaligned(o_misaligned)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    function automatic bit br_cond(input logic [2:0] f3, input bit z, input bit n);
        case (f3)
            3'd0: return z;
            3'd1: return !z;
            3'd4: return n;
            3'd5: return !n;
            default: return 0;
        endcase
    endfunction

    function automatic logic [31:0] load_val(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] rd);
        int unsigned b = addr % 4;
        int unsigned bv = (rd >> (8 * b)) % 256;
        int unsigned hv = (rd >> (16 * (b / 2))) % 65536;
        case (f3)
            3'd0: return (bv >= 128) ? 32'(bv) - 32'd256 : 32'(bv);
            3'd1: return (hv >= 32768) ? 32'(hv) - 32'd65536 : 32'(hv);
            3'd4: return 32'(bv);
            3'd5: return 32'(hv);
            default: return rd;
        endcase
    endfunction

    // Issues the currently driven op, services its memory access after k wait
    // cycles with read data rdata, and checks everything against the model.
    task automatic run_op(input int k, input logic [31:0] rdata);
        bit mem = i_MemRead || i_MemWrite;
        bit half = (i_funct3 == 3'd1) || (i_funct3 == 3'd5);
        bit word = (i_funct3 == 3'd2);
        bit mis = 0;
        int unsigned b = i_ALUResult % 4;
        logic [31:0] exp_res, exp_wd;
        logic [3:0] exp_be;
        bit exp_rw;
`ifdef MEM_MISALIGN_TRAP_EN
        mis = mem && ((half && (b % 2 == 1)) || (word && b != 0));
`endif
        exp_be = half ? 4'(3 << (2 * (b / 2))) : word ? 4'hF : 4'(1 << b);
        exp_wd = half ? (i_register2 % 65536) * 32'h00010001 :
                 word ? i_register2 : (i_register2 % 256) * 32'h01010101;
        exp_rw = i_RegWrite && !i_MemWrite && !mis;
        exp_res = (i_MemRead && !i_MemWrite && i_MemToReg && !mis) ? load_val(i_funct3, i_ALUResult, rdata) : i_ALUResult;
        check("ready_before", 32'(o_ready), 1);
        i_valid = 1;
        tick();
        i_valid = 0;
        if (mem && !mis) begin
            check("req", 32'(o_mem_req), 1);
            check("ready_busy", 32'(o_ready), 0);
            check("valid_busy", 32'(o_valid), 0);
            check("we", 32'(o_mem_we), 32'(i_MemWrite));
            check("addr", o_mem_addr, i_ALUResult - b);
            if (i_MemWrite) begin
                check("be", 32'(o_mem_be), 32'(exp_be));
                check("wdata", o_mem_wdata, exp_wd);
            end
            repeat (k) begin
                tick();
                check("req_hold", 32'(o_mem_req), 1);
                check("addr_hold", o_mem_addr, i_ALUResult - b);
            end
            i_mem_ack = 1;
            i_mem_rdata = rdata;
            tick();
            i_mem_ack = 0;
            check("req_drop", 32'(o_mem_req), 0);
        end else begin
            check("no_req", 32'(o_mem_req), 0);
        end
        check("valid", 32'(o_valid), 1);
        check("result", o_result, exp_res);
        check("rd", 32'(o_rd), 32'(i_rd));
        check("regwrite", 32'(o_RegWrite), 32'(exp_rw));
        check("pcsrc", 32'(o_PCSrc), 32'(i_Branch && br_cond(i_funct3, i_zero, i_negative)));
        check("pcbranch", o_PCBranch, i_PCBranch);
        check("misaligned", 32'(o_misaligned), 32'(mis));
        last_result = exp_res;
    endtask

    task automatic idle_check();
        i_mem_ack = 1'($urandom);
        i_mem_rdata = $urandom;
        tick();
        i_mem_ack = 0;
        check("idle_valid", 32'(o_valid), 0);
        check("idle_regwrite", 32'(o_RegWrite), 0);
        check("idle_pcsrc", 32'(o_PCSrc), 0);
        check("idle_hold", o_result, last_result);
        check("idle_req", 32'(o_mem_req), 0);
    endtask

    task automatic set_op(input bit mr, input bit mw, input bit m2r, input bit rw, input bit br,
                          input logic [2:0] f3, input logic [31:0] alu, input logic [31:0] r2,
                          input logic [4:0] rd, input logic [31:0] pcb, input bit z, input bit n);
        i_MemRead = mr; i_MemWrite = mw; i_MemToReg = m2r; i_RegWrite = rw; i_Branch = br;
        i_funct3 = f3; i_ALUResult = alu; i_register2 = r2; i_rd = rd; i_PCBranch = pcb;
        i_zero = z; i_negative = n;
    endtask

    initial begin
        logic [2:0] ld_f3 [5];
        ld_f3[0] = 3'd0; ld_f3[1] = 3'd1; ld_f3[2] = 3'd2; ld_f3[3] = 3'd4; ld_f3[4] = 3'd5;
        #12;
        check("rst_ready", 32'(o_ready), 1);
        check("rst_valid", 32'(o_valid), 0);
        check("rst_req", 32'(o_mem_req), 0);
        check("rst_result", o_result, 0);
        check("rst_be", 32'(o_mem_be), 0);
        i_rst = 0;
        tick();
        set_op(0, 0, 0, 1, 0, 3'd0, 32'h10, 0, 5'd5, 32'h0, 0, 0);
        run_op(0, 0);
        idle_check();
        set_op(1, 0, 1, 1, 0, 3'd0, 32'h103, 0, 5'd7, 32'h0, 0, 0);
        run_op(2, 32'h80FFFFFF);
        idle_check();
        set_op(0, 1, 0, 1, 0, 3'd1, 32'h202, 32'h0000BEEF, 5'd3, 32'h0, 0, 0);
        run_op(1, 0);
        idle_check();
        set_op(0, 0, 0, 0, 1, 3'd1, 32'h0, 0, 5'd0, 32'h40, 0, 0);
        run_op(0, 0);
        idle_check();
        set_op(1, 0, 1, 1, 0, 3'd2, 32'h301, 0, 5'd9, 32'h0, 0, 0);
        run_op(0, 32'h12345678);
        idle_check();
        set_op(1, 1, 1, 1, 0, 3'd2, 32'h400, 32'hCAFEF00D, 5'd4, 32'h0, 0, 0);
        run_op(0, 32'hFFFFFFFF);
        idle_check();
        set_op(0, 0, 0, 1, 0, 3'd0, 32'hA, 0, 5'd1, 32'h0, 0, 0);
        i_valid = 1;
        tick();
        check("b2b_valid1", 32'(o_valid), 1);
        check("b2b_res1", o_result, 32'hA);
        i_ALUResult = 32'hB; i_rd = 5'd2;
        tick();
        i_valid = 0;
        check("b2b_valid2", 32'(o_valid), 1);
        check("b2b_res2", o_result, 32'hB);
        check("b2b_rd2", 32'(o_rd), 2);
        last_result = 32'hB;
        idle_check();
        set_op(1, 0, 1, 1, 0, 3'd0, 32'h500, 0, 5'd6, 32'h0, 0, 0);
        i_valid = 1;
        tick();
        i_valid = 0;
        check("abort_req_before", 32'(o_mem_req), 1);
        #2 i_rst = 1;
        #1;
        check("abort_req", 32'(o_mem_req), 0);
        check("abort_ready", 32'(o_ready), 1);
        check("abort_valid", 32'(o_valid), 0);
        @(negedge i_clk) i_rst = 0;
        last_result = 0;
        i_mem_ack = 1;
        tick();
        i_mem_ack = 0;
        check("stray_ack_valid", 32'(o_valid), 0);
        check("stray_ack_req", 32'(o_mem_req), 0);
        check("stray_ack_ready", 32'(o_ready), 1);
        for (int i = 0; i < 200; i++) begin
            int kind = $urandom_range(0, 3);
            bit mr = (kind == 1) || (kind == 3);
            bit mw = (kind >= 2);
            logic [2:0] f3 = mr && !mw ? ld_f3[$urandom_range(0, 4)] :
                             mw ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 7));
            set_op(mr, mw, 1'($urandom), 1'($urandom), 1'($urandom), f3, $urandom,
                   $urandom, 5'($urandom), $urandom, 1'($urandom), 1'($urandom));
            run_op($urandom_range(0, 3), $urandom);
            repeat ($urandom_range(1, 2)) idle_check();
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
